// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator side of the ALU port. Accepts one instruction per
// valid/ready handshake, issues it to a 1-cycle registered ALU, captures the
// result and holds a writeback/memory/branch response until it is consumed.
module alu_issue_ctrl #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned IMM_W = 14,
   parameter int unsigned RA_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [31:0]       instr,
   output logic [RA_W-1:0]   rf_raddr1,
   output logic [RA_W-1:0]   rf_raddr2,
   input  logic [XLEN-1:0]   rf_rdata1,
   input  logic [XLEN-1:0]   rf_rdata2,
   output logic [3:0]        alu_op,
   output logic [XLEN-1:0]   alu_rs1,
   output logic [XLEN-1:0]   alu_rs2,
   output logic [IMM_W-1:0]  alu_imm,
   output logic [RA_W-1:0]   alu_sa,
   output logic              alu_en,
   input  logic [XLEN-1:0]   alu_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              wb_en,
   output logic [RA_W-1:0]   wb_rd,
   output logic [XLEN-1:0]   wb_data,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic              br_taken,
   output logic              illegal,
   output logic              busy
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_ANDI = 4'b0100;
   localparam logic [3:0] OP_ADDI = 4'b0101;
   localparam logic [3:0] OP_LW   = 4'b0110;
   localparam logic [3:0] OP_SW   = 4'b0111;
   localparam logic [3:0] OP_BEQ  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b1011;
   localparam logic [3:0] OP_SRL  = 4'b1100;
   localparam logic [3:0] OP_SLLV = 4'b1101;
   localparam logic [3:0] OP_SRLV = 4'b1110;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state;
   logic [31:4]       instr_q;
   logic [XLEN-1:0]   wdata_q;

   logic [3:0]        op_q;
   logic [RA_W-1:0]   rd_q;

   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         4'b0011, 4'b1001, 4'b1010, 4'b1111: is_legal = 1'b0;
         default:                            is_legal = 1'b1;
      endcase
   endfunction

   function automatic logic writes_reg(input logic [3:0] op);
      case (op)
         OP_AND, OP_ADD, OP_SUB, OP_ANDI, OP_ADDI, OP_LW,
         OP_SLL, OP_SRL, OP_SLLV, OP_SRLV: writes_reg = 1'b1;
         default:                          writes_reg = 1'b0;
      endcase
   endfunction

   assign op_q        = instr_q[31:28];
   assign rd_q        = instr_q[27:23];
   assign rf_raddr1   = instr_q[22:18];
   // Stores read their data register through the second read port.
   assign rf_raddr2   = (op_q == OP_SW) ? rd_q : instr_q[17:13];
   assign alu_op      = (op_q == OP_BEQ) ? OP_SUB : op_q;
   assign alu_rs1     = rf_rdata1;
   assign alu_rs2     = rf_rdata2;
   assign alu_imm     = instr_q[4 +: IMM_W];
   assign alu_sa      = instr_q[12:8];
   assign instr_ready = (state == S_IDLE);
   assign busy        = (state != S_IDLE);

   // Issue FSM with registered ALU enable and held response outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         instr_q   <= '0;
         wdata_q   <= '0;
         alu_en    <= 1'b0;
         out_valid <= 1'b0;
         wb_en     <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         br_taken  <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  instr_q <= instr[31:4];
                  if (is_legal(instr[31:28])) begin
                     state  <= S_ISSUE;
                     alu_en <= 1'b1;
                  end else begin
                     // Illegal ops skip the ALU; only the illegal flag is raised.
                     state     <= S_RESP;
                     out_valid <= 1'b1;
                     illegal   <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               alu_en  <= 1'b0;
               wdata_q <= rf_rdata2;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               state     <= S_RESP;
               out_valid <= 1'b1;
               wb_en     <= writes_reg(op_q) && (rd_q != '0);
               wb_rd     <= rd_q;
               wb_data   <= alu_result;
               mem_rd    <= (op_q == OP_LW);
               mem_wr    <= (op_q == OP_SW);
               mem_addr  <= alu_result;
               mem_wdata <= (op_q == OP_SW) ? wdata_q : '0;
               br_taken  <= (op_q == OP_BEQ) && (alu_result == '0);
            end
            S_RESP: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  wb_en     <= 1'b0;
                  wb_rd     <= '0;
                  wb_data   <= '0;
                  mem_rd    <= 1'b0;
                  mem_wr    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  br_taken  <= 1'b0;
                  illegal   <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized checks of alu_issue_ctrl against a
// transaction-level model (accept time, expected response contents).
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        instr_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] instr = '0;
   logic        instr_ready, alu_en, out_valid, wb_en, mem_rd, mem_wr, br_taken, illegal, busy;
   logic [4:0]  rf_raddr1, rf_raddr2, alu_sa, wb_rd;
   logic [31:0] rf_rdata1, rf_rdata2, alu_rs1, alu_rs2, wb_data, mem_addr, mem_wdata;
   logic [31:0] alu_result = '0;
   logic [3:0]  alu_op;
   logic [13:0] alu_imm;

   logic [31:0] regs [32];
   int          checks = 0;
   int          failures = 0;
   int          rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled
   int          en_cnt = 0;
   logic [3:0]  last_aop = '0;

   // model state: one transaction in flight at most
   bit          m_busy = 0, m_en = 0, m_resp = 0;
   int          m_cnt = 0;
   logic [3:0]  e_aop;
   logic [4:0]  e_r1, e_r2, e_sa, e_rd;
   logic [13:0] e_imm;
   logic [31:0] e_a, e_b, e_wb_data, e_mem_addr, e_mem_wdata;
   logic [4:0]  e_flags;   // {wb_en, mem_rd, mem_wr, br_taken, illegal}

   alu_issue_ctrl #(.XLEN(32), .IMM_W(14), .RA_W(5)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .alu_op(alu_op),
      .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_sa(alu_sa),
      .alu_en(alu_en), .alu_result(alu_result), .out_valid(out_valid),
      .out_ready(out_ready), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .br_taken(br_taken), .illegal(illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   assign rf_rdata1 = regs[rf_raddr1];
   assign rf_rdata2 = regs[rf_raddr2];

   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [13:0] imm,
                                          input logic [4:0] sa);
      logic [31:0] sx;
      sx = {{18{imm[13]}}, imm};
      case (op)
         4'b0000: alu_fn = a & b;
         4'b0001: alu_fn = a + b;
         4'b0010: alu_fn = a - b;
         4'b0100: alu_fn = a & {18'b0, imm};
         4'b0101, 4'b0110, 4'b0111: alu_fn = a + sx;
         4'b1011: alu_fn = a << sa;
         4'b1100: alu_fn = a >> sa;
         4'b1101: alu_fn = a << b[4:0];
         4'b1110: alu_fn = a >> b[4:0];
         default: alu_fn = 32'hBAD0_BAD0;
      endcase
   endfunction

   function automatic logic [31:0] mk_r(input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [4:0] sa);
      mk_r = {op, rd, rs1, rs2, sa, 8'h00};
   endfunction

   function automatic logic [31:0] mk_i(input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [13:0] imm);
      mk_i = {op, rd, rs1, imm, 4'h0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
      end
   endtask

   // ALU stand-in: registered result one cycle after alu_en, garbage otherwise
   always @(posedge clk) alu_result <= alu_en ? alu_fn(alu_op, alu_rs1, alu_rs2, alu_imm, alu_sa)
                                              : $urandom;

   // Transaction model: accept when idle, response 2 edges later (1 for illegal)
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy = 0; m_en = 0; m_resp = 0; m_cnt = 0;
      end else if (m_resp) begin
         if (out_ready) begin m_resp = 0; m_busy = 0; end
      end else if (m_busy) begin
         m_en = 0;
         m_cnt--;
         if (m_cnt == 0) m_resp = 1;
      end else if (instr_valid) begin
         logic [3:0]  op;
         logic        legal, wr;
         logic [31:0] res;
         op    = instr[31:28];
         legal = !(op inside {4'd3, 4'd9, 4'd10, 4'd15});
         e_rd  = instr[27:23];
         e_r1  = instr[22:18];
         e_r2  = (op == 4'd7) ? e_rd : instr[17:13];
         e_sa  = instr[12:8];
         e_imm = instr[17:4];
         e_aop = (op == 4'd8) ? 4'd2 : op;
         e_a   = regs[e_r1];
         e_b   = regs[e_r2];
         res   = alu_fn(e_aop, e_a, e_b, e_imm, e_sa);
         wr    = legal && (op != 4'd7) && (op != 4'd8) && (e_rd != 0);
         e_flags     = {wr, op == 4'd6, op == 4'd7, op == 4'd8 && res == 0, !legal};
         e_wb_data   = legal ? res : 32'h0;
         e_mem_addr  = legal ? res : 32'h0;
         e_mem_wdata = (op == 4'd7) ? regs[e_rd] : 32'h0;
         m_busy = 1;
         if (legal) begin m_en = 1; m_cnt = 2; end
         else m_resp = 1;
      end
   end

   // Compare DUT outputs against the model every cycle
   always @(negedge clk) begin
      chk("instr_ready", {31'b0, instr_ready}, {31'b0, !m_busy});
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("alu_en", {31'b0, alu_en}, {31'b0, m_en});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_resp});
      if (alu_en) begin en_cnt++; last_aop = alu_op; end
      if (m_en) begin
         chk("alu_op", {28'b0, alu_op}, {28'b0, e_aop});
         chk("rf_raddr1", {27'b0, rf_raddr1}, {27'b0, e_r1});
         chk("rf_raddr2", {27'b0, rf_raddr2}, {27'b0, e_r2});
         chk("alu_rs1", alu_rs1, e_a);
         chk("alu_rs2", alu_rs2, e_b);
         chk("alu_imm", {18'b0, alu_imm}, {18'b0, e_imm});
         chk("alu_sa", {27'b0, alu_sa}, {27'b0, e_sa});
      end
      if (m_resp) begin
         chk("resp_flags", {27'b0, wb_en, mem_rd, mem_wr, br_taken, illegal}, {27'b0, e_flags});
         chk("wb_data", wb_data, e_wb_data);
         chk("mem_addr", mem_addr, e_mem_addr);
         chk("mem_wdata", mem_wdata, e_mem_wdata);
         if (e_flags[4]) chk("wb_rd", {27'b0, wb_rd}, {27'b0, e_rd});
      end else begin
         chk("idle_flags", {27'b0, wb_en, mem_rd, mem_wr, br_taken, illegal}, 32'h0);
      end
   end

   // out_ready driver
   initial begin
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       out_ready = ($urandom_range(0, 9) < 7);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
         endcase
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [31:0] i);
      int unsigned n = 0;
      logic        acc = 1'b0;
      instr = i;
      instr_valid = 1'b1;
      while (!acc && n < 100) begin
         acc = instr_ready;
         @(posedge clk); #1;
         n++;
      end
      instr_valid = 1'b0;
      instr = $urandom;
      if (!acc) chk("accept_timeout", 32'h0, 32'h1);
   endtask

   task automatic wait_resp();
      int unsigned n = 0;
      do begin @(negedge clk); n++; end while (!out_valid && n < 100);
      if (!out_valid) chk("resp_timeout", 32'h0, 32'h1);
   endtask

   initial begin
      for (int k = 0; k < 32; k++) regs[k] = (k % 2) ? $urandom_range(0, 3) : $urandom;
      #2 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_alu_en", {31'b0, alu_en}, 32'h0);
      chk("rst_ready", {31'b0, instr_ready}, 32'h1);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_raddr", {22'b0, rf_raddr1, rf_raddr2}, 32'h0);
      chk("rst_fields", {14'b0, alu_op, alu_imm}, 32'h0);
      reset = 1'b0;
      sync();

      // ADD r3 = r1 + r2
      regs[1] = 32'd5; regs[2] = 32'd7; en_cnt = 0;
      issue(mk_r(4'b0001, 5'd3, 5'd1, 5'd2, 5'd0));
      wait_resp();
      chk("model_add", e_wb_data, 32'd12);
      chk("add_wb_en", {31'b0, wb_en}, 32'h1);
      chk("add_wb_rd", {27'b0, wb_rd}, 32'd3);
      chk("add_wb_data", wb_data, 32'd12);
      chk("add_en_pulses", en_cnt, 32'd1);
      sync();

      // BEQ taken / not taken
      regs[1] = 32'h55; regs[2] = 32'h55;
      issue(mk_r(4'b1000, 5'd9, 5'd1, 5'd2, 5'd0));
      wait_resp();
      chk("beq_aop", {28'b0, last_aop}, 32'h2);
      chk("beq_taken", {31'b0, br_taken}, 32'h1);
      chk("beq_wb_en", {31'b0, wb_en}, 32'h0);
      sync();
      regs[2] = 32'h54;
      issue(mk_r(4'b1000, 5'd9, 5'd1, 5'd2, 5'd0));
      wait_resp();
      chk("beq_not_taken", {31'b0, br_taken}, 32'h0);
      sync();

      // SW imm=8, base 0x100, data 0xDEAD
      regs[4] = 32'h100; regs[5] = 32'hDEAD;
      issue(mk_i(4'b0111, 5'd5, 5'd4, 14'd8));
      wait_resp();
      chk("model_sw", e_mem_addr, 32'h108);
      chk("sw_mem_wr", {31'b0, mem_wr}, 32'h1);
      chk("sw_mem_addr", mem_addr, 32'h108);
      chk("sw_mem_wdata", mem_wdata, 32'hDEAD);
      chk("sw_wb_mem_rd", {30'b0, wb_en, mem_rd}, 32'h0);
      sync();

      // Illegal op: response one cycle after accept, no ALU enable
      en_cnt = 0;
      issue(32'hF000_0000 | ($urandom & 32'h0FFF_FFFF));
      chk("ill_valid", {31'b0, out_valid}, 32'h1);
      chk("ill_flag", {31'b0, illegal}, 32'h1);
      chk("ill_other_flags", {28'b0, wb_en, mem_rd, mem_wr, br_taken}, 32'h0);
      sync();
      chk("ill_no_en", en_cnt, 32'd0);

      // Stalled response with a second instruction waiting
      rdy_mode = 2;
      regs[6] = 32'h1234; regs[7] = 32'h1;
      issue(mk_r(4'b0001, 5'd8, 5'd6, 5'd7, 5'd0));
      wait_resp();
      chk("hold_first", wb_data, 32'h1235);
      sync();
      instr = mk_r(4'b0010, 5'd9, 5'd6, 5'd7, 5'd0);
      instr_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("hold_ready", {31'b0, instr_ready}, 32'h0);
         chk("hold_valid", {31'b0, out_valid}, 32'h1);
         chk("hold_data", wb_data, 32'h1235);
      end
      sync();
      rdy_mode = 1;
      issue(mk_r(4'b0010, 5'd9, 5'd6, 5'd7, 5'd0));
      wait_resp();
      chk("hold_second", wb_data, 32'h1233);
      sync();

      // Reset asserted during WAIT
      regs[1] = 32'd5; regs[2] = 32'd7;
      issue(mk_r(4'b0001, 5'd3, 5'd1, 5'd2, 5'd0));
      sync();
      chk("rwait_busy", {31'b0, busy}, 32'h1);
      reset = 1'b1;
      #1;
      chk("rwait_alu_en", {31'b0, alu_en}, 32'h0);
      chk("rwait_out_valid", {31'b0, out_valid}, 32'h0);
      chk("rwait_idle", {31'b0, busy}, 32'h0);
      repeat (2) sync();
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rwait_no_resp", {31'b0, out_valid}, 32'h0);
      end
      sync();
      issue(mk_r(4'b0001, 5'd10, 5'd1, 5'd2, 5'd0));
      wait_resp();
      chk("rwait_next", wb_data, 32'd12);
      sync();

      // Randomized traffic with random backpressure
      rdy_mode = 0;
      for (int k = 0; k < 32; k++) regs[k] = (k % 2) ? $urandom_range(0, 3) : $urandom;
      for (int t = 0; t < 300; t++) begin
         logic [31:0] ri;
         ri = $urandom;
         if ($urandom_range(0, 7) == 0) ri[27:23] = 5'd0;
         issue(ri);
         repeat ($urandom_range(0, 2)) sync();
      end
      rdy_mode = 1;
      begin
         int unsigned n = 0;
         while (m_busy && n < 100) begin sync(); n++; end
         if (m_busy) chk("drain_timeout", 32'h0, 32'h1);
      end
      repeat (2) sync();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
